// File: rtl/elevator_pkg.sv
// Shared elevator types: dispatcher state encoding, direction constants and floor-index width helpers.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    ARRIVE = 2'd2,
    DOOR   = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Index width for a count of items; never narrower than one bit.
  function automatic int floor_w(input int count);
    return (count > 1) ? clog2(count) : 1;
  endfunction

endpackage

// File: rtl/elevator_request_scan.sv
// Combinational request summary relative to one floor: any request above, below, or at that floor.
module elevator_request_scan
  import elevator_pkg::*;
#(
  parameter  int FLOOR_COUNT = 7,
  localparam int FLOOR_W     = floor_w(FLOOR_COUNT)
) (
  input  logic [FLOOR_COUNT-1:0] queue_data,
  input  logic [FLOOR_W-1:0]     current_floor,
  output logic                   above,
  output logic                   below,
  output logic                   here
);

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    here  = 1'b0;
    for (int i = 0; i < FLOOR_COUNT; i++) begin
      if (FLOOR_W'(i) > current_floor) above = above | queue_data[i];
      if (FLOOR_W'(i) < current_floor) below = below | queue_data[i];
      if (FLOOR_W'(i) == current_floor) here = here | queue_data[i];
    end
  end

endmodule

// File: rtl/elevator_dispatcher.sv
// SCAN dispatcher: one floor per TRAVEL_CYCLES, door held DOOR_CYCLES, 1-clock clear strobe per stop.
// Decisions land 1 clock after seen; return-to-floor-0 after HOME_TIMEOUT idle via ELEVATOR_DISPATCH_IDLE_HOME_EN.
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter  int FLOOR_COUNT   = 7,
  parameter  int TRAVEL_CYCLES = 50,
  parameter  int DOOR_CYCLES   = 100,
  parameter  int HOME_TIMEOUT  = 200,
  localparam int FLOOR_W       = floor_w(FLOOR_COUNT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [FLOOR_COUNT-1:0] queue_data,
  output logic                   r_nwr,
  output logic                   clear_bit,
  output logic [FLOOR_COUNT-1:0] clear_mask,
  output logic [FLOOR_W-1:0]     current_floor,
  output logic                   direction,
  output logic                   moving,
  output logic                   door_open
);

  localparam int TIMER_W = floor_w((TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES);
  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

  if (TRAVEL_CYCLES < 1 || DOOR_CYCLES < 1 || HOME_TIMEOUT < 1) begin : g_bad_cfg
    $error("elevator_dispatcher: cycle parameters must be at least 1");
  end

  state_t               state, state_n;
  logic [TIMER_W-1:0]   timer, timer_n;
  logic [FLOOR_W-1:0]   floor_n, step_floor;
  logic                 dir_n;
  logic                 above, below, here;
  logic                 step_above, step_below, step_here;
  logic                 ahead, behind, step_ahead;

`ifdef ELEVATOR_DISPATCH_IDLE_HOME_EN
  localparam int IDLE_W = floor_w(HOME_TIMEOUT);
  localparam logic [IDLE_W-1:0] HOME_LOAD = IDLE_W'(HOME_TIMEOUT - 1);
  logic                 homing, homing_n;
  logic [IDLE_W-1:0]    idle_cnt, idle_cnt_n;
`endif

  // Second scanner looks at the floor the car is about to reach, so arrival and
  // re-evaluation happen on the same edge as the floor change.
  assign step_floor = (direction == DIR_DOWN) ? current_floor - 1'b1 : current_floor + 1'b1;

  elevator_request_scan #(.FLOOR_COUNT(FLOOR_COUNT)) u_scan_here (
    .queue_data    (queue_data),
    .current_floor (current_floor),
    .above         (above),
    .below         (below),
    .here          (here)
  );

  elevator_request_scan #(.FLOOR_COUNT(FLOOR_COUNT)) u_scan_step (
    .queue_data    (queue_data),
    .current_floor (step_floor),
    .above         (step_above),
    .below         (step_below),
    .here          (step_here)
  );

  assign ahead      = (direction == DIR_UP) ? above : below;
  assign behind     = (direction == DIR_UP) ? below : above;
  assign step_ahead = (direction == DIR_UP) ? step_above : step_below;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      timer         <= '0;
      current_floor <= '0;
      direction     <= DIR_UP;
`ifdef ELEVATOR_DISPATCH_IDLE_HOME_EN
      homing        <= 1'b0;
      idle_cnt      <= '0;
`endif
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      current_floor <= floor_n;
      direction     <= dir_n;
`ifdef ELEVATOR_DISPATCH_IDLE_HOME_EN
      homing        <= homing_n;
      idle_cnt      <= idle_cnt_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    floor_n = current_floor;
    dir_n   = direction;
`ifdef ELEVATOR_DISPATCH_IDLE_HOME_EN
    homing_n   = homing;
    idle_cnt_n = '0;
`endif
    case (state)
      IDLE: begin
        if (here) begin
          state_n = ARRIVE;
        end else if (ahead) begin
          state_n = MOVE;
          timer_n = TRAVEL_LOAD;
        end else if (behind) begin
          state_n = MOVE;
          dir_n   = ~direction;
          timer_n = TRAVEL_LOAD;
        end
`ifdef ELEVATOR_DISPATCH_IDLE_HOME_EN
        // Reaching here means queue_data is all zero.
        else if (current_floor != '0) begin
          if (idle_cnt == HOME_LOAD) begin
            state_n  = MOVE;
            dir_n    = DIR_DOWN;
            timer_n  = TRAVEL_LOAD;
            homing_n = 1'b1;
          end else begin
            idle_cnt_n = idle_cnt + 1'b1;
          end
        end
`endif
      end
      MOVE: begin
        if (timer != '0) begin
          timer_n = timer - 1'b1;
        end else begin
          floor_n = step_floor;
          if (step_here) begin
            state_n = ARRIVE;
          end else if (step_ahead) begin
            timer_n = TRAVEL_LOAD;
          end else begin
            state_n = IDLE;
          end
`ifdef ELEVATOR_DISPATCH_IDLE_HOME_EN
          homing_n = 1'b0;
          if (homing && (queue_data == '0)) begin
            state_n  = (step_floor != '0) ? MOVE : IDLE;
            timer_n  = TRAVEL_LOAD;
            homing_n = (step_floor != '0);
          end
`endif
        end
      end
      ARRIVE: begin
        state_n = DOOR;
        timer_n = DOOR_LOAD;
      end
      DOOR: begin
        if (timer == '0) state_n = IDLE;
        else             timer_n = timer - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    clear_mask = '0;
    for (int i = 0; i < FLOOR_COUNT; i++)
      clear_mask[i] = (state == ARRIVE) && (current_floor == FLOOR_W'(i));
  end

  assign clear_bit = (state == ARRIVE);
  assign r_nwr     = ~clear_bit;
  assign moving    = (state == MOVE);
  assign door_open = (state == DOOR);

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Bench for elevator_dispatcher: table vectors, hand sequences and random request sets against a SCAN model.
module tb_elevator_dispatcher;
  localparam int TRAV = 4;
  localparam int DOOR = 6;
  localparam int HOME = 10;

  logic       clk;
  logic       reset;
  logic [6:0] queue_data;
  logic       r_nwr, clear_bit, direction, moving, door_open;
  logic [6:0] clear_mask;
  logic [2:0] current_floor;

  int tests = 0;
  int fails = 0;

  int model_floor = 0;
  bit model_dir   = 1'b1;
  int exp_stop[$];
  int exp_edge[$];
  int obs_stop[$];
  int end_edge;

  elevator_dispatcher #(
    .FLOOR_COUNT(7), .TRAVEL_CYCLES(TRAV), .DOOR_CYCLES(DOOR), .HOME_TIMEOUT(HOME)
  ) dut (
    .clk(clk), .reset(reset), .queue_data(queue_data), .r_nwr(r_nwr),
    .clear_bit(clear_bit), .clear_mask(clear_mask), .current_floor(current_floor),
    .direction(direction), .moving(moving), .door_open(door_open)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [6:0] m);
    int idx;
    idx = -1;
    if ($countones(m) != 1) return -1;
    for (int i = 0; i < 7; i++) if (m[i]) idx = i;
    return idx;
  endfunction

  function automatic bit req_toward(input logic [6:0] r, input int f, input bit d);
    for (int i = 0; i < 7; i++)
      if (r[i] && (d ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  // SCAN over a static request set: serve here, then nearest in travel direction,
  // reversing only when nothing remains ahead. Arrival edges counted from the
  // first clock edge that sees the requests.
  task automatic model_plan(input logic [6:0] r);
    int f, t, nxt, a;
    bit d;
    logic [6:0] rem;
    f = model_floor; d = model_dir; t = 1; rem = r; a = 0;
    exp_stop.delete(); exp_edge.delete();
    while (rem != 7'd0) begin
      if (rem[f]) nxt = f;
      else begin
        if (!req_toward(rem, f, d)) d = !d;
        nxt = f;
        do nxt = d ? nxt + 1 : nxt - 1; while (!rem[nxt]);
      end
      a = t + ((nxt > f) ? nxt - f : f - nxt) * TRAV;
      exp_stop.push_back(nxt);
      exp_edge.push_back(a);
      rem[nxt] = 1'b0;
      f = nxt;
      t = a + DOOR + 2;
    end
    end_edge = (exp_edge.size() == 0) ? 3 : a + DOOR + 1;
    model_floor = f;
    model_dir = d;
  endtask

  // Must be entered at a falling edge. Bench acts as the queue: clears on strobe.
  task automatic run_scan(input string tag, input logic [6:0] r);
    int edges[$];
    logic [6:0] pending;
    model_plan(r);
    obs_stop.delete();
    pending = r;
    queue_data = r;
    for (int n = 1; n <= end_edge; n++) begin
      @(negedge clk);
      if (clear_bit) begin
        edges.push_back(n);
        obs_stop.push_back(onehot_idx(clear_mask));
        check({tag, " r_nwr at clear"}, r_nwr, 0);
        pending = pending & ~clear_mask;
      end
      queue_data = pending;
    end
    check({tag, " stop count"}, edges.size(), exp_edge.size());
    for (int i = 0; i < exp_edge.size() && i < edges.size(); i++) begin
      check($sformatf("%s stop%0d floor", tag, i), obs_stop[i], exp_stop[i]);
      check($sformatf("%s stop%0d clock", tag, i), edges[i], exp_edge[i]);
    end
    check({tag, " end floor"}, current_floor, model_floor);
    check({tag, " end dir"}, direction, model_dir);
    check({tag, " end idle"}, {moving, door_open}, 0);
  endtask

  typedef struct {
    logic [6:0] reqs;
    int nstops;
    int stop0;
    int stop1;
    int fin_floor;
    int fin_dir;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int clr_n[$];
    int door_cnt, clears, moves, first_move;

    vecs[0] = '{7'b0000001, 1, 0, -1, 0, 1};
    vecs[1] = '{7'b0001000, 1, 3, -1, 3, 1};
    vecs[2] = '{7'b0100010, 2, 5,  1, 1, 0};
    vecs[3] = '{7'b1000001, 2, 0,  6, 6, 1};
    vecs[4] = '{7'b0000100, 1, 2, -1, 2, 0};

    // Reset hold and quiet idle
    reset = 1'b0;
    queue_data = 7'd0;
    repeat (3) @(negedge clk);
    check("rst floor", current_floor, 0);
    check("rst dir", direction, 1);
    check("rst moving", moving, 0);
    check("rst door", door_open, 0);
    check("rst clear_bit", clear_bit, 0);
    check("rst clear_mask", clear_mask, 0);
    check("rst r_nwr", r_nwr, 1);
    reset = 1'b1;
    clears = 0; moves = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (clear_bit) clears++;
      if (moving || door_open) moves++;
    end
    check("idle20 clears", clears, 0);
    check("idle20 activity", moves, 0);
    check("idle20 floor", current_floor, 0);

    // Re-request of the current floor while the door is open is served again
    queue_data = 7'b0000001;
    door_cnt = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (clear_bit) begin
        clr_n.push_back(n);
        check("rereq mask", clear_mask, 1);
        queue_data = 7'd0;
      end
      if (door_open && n < 9) door_cnt++;
      if (n == 3) queue_data = 7'b0000001;
    end
    check("rereq clears", clr_n.size(), 2);
    if (clr_n.size() == 2) begin
      check("rereq first clk", clr_n[0], 1);
      check("rereq second clk", clr_n[1], 9);
    end
    check("rereq door clocks", door_cnt, DOOR);
    check("rereq idle", {moving, door_open}, 0);

    for (int i = 0; i < 5; i++) begin
      run_scan($sformatf("vec%0d", i), vecs[i].reqs);
      check($sformatf("vec%0d nstops", i), obs_stop.size(), vecs[i].nstops);
      if (obs_stop.size() > 0) check($sformatf("vec%0d s0", i), obs_stop[0], vecs[i].stop0);
      if (obs_stop.size() > 1 && vecs[i].nstops > 1)
        check($sformatf("vec%0d s1", i), obs_stop[1], vecs[i].stop1);
      check($sformatf("vec%0d tbl floor", i), current_floor, vecs[i].fin_floor);
      check($sformatf("vec%0d tbl dir", i), direction, vecs[i].fin_dir);
    end

    // Reset during MOVE at floor 2 heading down, timer mid-count
    queue_data = 7'b0000001;
    @(negedge clk);
    @(negedge clk);
    check("midmove moving", moving, 1);
    check("midmove floor", current_floor, 2);
    check("midmove dir", direction, 0);
    reset = 1'b0;
    #1;
    check("arst floor", current_floor, 0);
    check("arst moving", moving, 0);
    check("arst dir", direction, 1);
    check("arst door", door_open, 0);
    check("arst r_nwr", r_nwr, 1);
    queue_data = 7'd0;
    @(negedge clk);
    reset = 1'b1;
    model_floor = 0;
    model_dir = 1'b1;

    // Per-floor timing from floor 0 to floor 3
    queue_data = 7'b0001000;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("trip moving", moving, 1);
        check("trip dir", direction, 1);
      end
      if (n == 4)  check("trip floor@4", current_floor, 0);
      if (n == 5)  check("trip floor@5", current_floor, 1);
      if (n == 8)  check("trip floor@8", current_floor, 1);
      if (n == 9)  check("trip floor@9", current_floor, 2);
      if (n == 13) begin
        check("trip floor@13", current_floor, 3);
        check("trip clear_bit", clear_bit, 1);
        check("trip clear_mask", clear_mask, 8);
      end
      if (clear_bit) queue_data = queue_data & ~clear_mask;
    end
    check("trip idle", {moving, door_open}, 0);
    model_floor = 3;
    model_dir = 1'b1;

    for (int k = 0; k < 8; k++)
      run_scan($sformatf("rnd%0d", k), 7'($urandom_range(1, 127)));

    run_scan("to4", 7'b0010000);

    clears = 0; moves = 0; first_move = -1;
`ifdef ELEVATOR_DISPATCH_IDLE_HOME_EN
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (moving && first_move < 0) first_move = n;
      if (clear_bit) clears++;
    end
    check("home start clk", first_move, HOME);
    check("home floor", current_floor, 0);
    check("home dir", direction, 0);
    check("home stopped", moving, 0);
    check("home clears", clears, 0);
`else
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (moving) moves++;
      if (clear_bit) clears++;
    end
    check("stay floor", current_floor, 4);
    check("stay moves", moves, 0);
    check("stay clears", clears, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
